// File: rtl/hls_seq_pkg.sv
// Shared definitions for the HLS ap_ctrl_hs start sequencer.
package hls_seq_pkg;

  localparam int unsigned STATE_W     = 3;
  localparam int unsigned DONE_SEEN_W = 1;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_GAP       = 3'd3,
    S_FINISH    = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

endpackage

// File: rtl/hls_cycle_timer.sv
// Loadable down-counter used for both the watchdog and the inter-run gap.
// expired is high on the enabled cycle that consumes the last count, so a
// load of N expires on the Nth enabled cycle; a load of 0 never expires.
module hls_cycle_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         expired
);

  logic [W-1:0] count;

  // Load takes priority over counting; the count parks at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = enable && (count == W'(1));

endmodule

// File: rtl/hls_ap_ctrl_seq.sv
// Converts the start generator's startCore level into the ap_ctrl_hs
// handshake, counts completed runs, spaces runs apart and watches for a hung core.
module hls_ap_ctrl_seq
  import hls_seq_pkg::*;
#(
  parameter int unsigned NUM_RUNS       = 1,
  parameter int unsigned GAP_CYCLES     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startCore,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_idle,
  output logic             ap_start,
  output logic             busy,
  output logic [CNT_W-1:0] run_count,
  output logic             run_done,
  output logic             all_done,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0] RUNS_TARGET = CNT_W'(NUM_RUNS);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] WD_LOAD     = CNT_W'(TIMEOUT_CYCLES);

  state_t                 state;
  logic [DONE_SEEN_W-1:0] done_seen;
  logic [CNT_W-1:0]       run_next;
  logic                   complete;
  logic                   last_run;
  logic                   enter_start;
  logic                   gap_load;
  logic                   wd_expired;
  logic                   gap_expired;

  // ap_idle is status only and never steers the sequencer.
  logic unused_idle;
  assign unused_idle = ap_idle;

  // Completion, end-of-sequence and START-entry decisions from sampled inputs.
  always_comb begin
    run_next    = run_count + 1'b1;
    complete    = ((state == S_START) && ap_ready && (ap_done || done_seen[0])) ||
                  ((state == S_WAIT_DONE) && ap_done);
    last_run    = (NUM_RUNS != 0) && (run_next == RUNS_TARGET);
    gap_load    = complete && !last_run && (GAP_CYCLES != 0);
    enter_start = ((state == S_IDLE) && startCore) ||
                  (complete && !last_run && (GAP_CYCLES == 0)) ||
                  ((state == S_GAP) && gap_expired);
  end

  hls_cycle_timer #(.W(CNT_W)) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .load       (enter_start),
    .load_value (WD_LOAD),
    .enable     ((TIMEOUT_CYCLES != 0) && ((state == S_START) || (state == S_WAIT_DONE))),
    .expired    (wd_expired)
  );

  hls_cycle_timer #(.W(CNT_W)) u_gap_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (gap_load),
    .load_value (GAP_LOAD),
    .enable     (state == S_GAP),
    .expired    (gap_expired)
  );

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      done_seen   <= '0;
      ap_start    <= 1'b0;
      busy        <= 1'b0;
      run_count   <= '0;
      run_done    <= 1'b0;
      all_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      run_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (startCore) begin
            state     <= S_START;
            ap_start  <= 1'b1;
            busy      <= 1'b1;
            done_seen <= '0;
          end
        end
        S_START, S_WAIT_DONE: begin
          // A completion on the watchdog's expiry cycle takes precedence.
          if (complete) begin
            run_count <= run_next;
            run_done  <= 1'b1;
            done_seen <= '0;
            if (last_run) begin
              state    <= S_FINISH;
              ap_start <= 1'b0;
              busy     <= 1'b0;
              all_done <= 1'b1;
            end else if (GAP_CYCLES == 0) begin
              state    <= S_START;
              ap_start <= 1'b1;
            end else begin
              state    <= S_GAP;
              ap_start <= 1'b0;
            end
          end else if (wd_expired) begin
            state       <= S_ERROR;
            ap_start    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else if (state == S_START) begin
            if (ap_ready) begin
              state    <= S_WAIT_DONE;
              ap_start <= 1'b0;
            end else if (ap_done) begin
              done_seen <= '1;
            end
          end
        end
        S_GAP: begin
          if (gap_expired) begin
            state    <= S_START;
            ap_start <= 1'b1;
          end
        end
        S_FINISH, S_ERROR: begin
          state <= state;
        end
        default: begin
          state    <= S_IDLE;
          ap_start <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/hls_ap_ctrl_seq.md
Name: hls_ap_ctrl_seq

Overview:
Downstream consumer of the regression-sim start generator's startCore level. Converts startCore into the HLS ap_ctrl_hs handshake for the core under test:
- drives ap_start and waits for ap_ready and ap_done;
- counts completed invocations;
- inserts an optional inter-run gap;
- flags a hung core with a watchdog.

Used in the memcached regression benches between the start generator and the HLS top.

Parameters:
NUM_RUNS, 1, number of invocations before stopping; 0 = free-running, never finishes
GAP_CYCLES, 0, idle cycles between a run's ap_done and the next ap_start
TIMEOUT_CYCLES, 1024, watchdog limit per run in cycles; 0 disables the watchdog
CNT_W, 16, width of run_count and of the internal gap/watchdog counters

Ports:
clk  in  1  single clock for the whole block
rst  in  1  asynchronous, active-low reset; asserted when 0
startCore  in  1  level from the start generator; sampled synchronously, stays high once set
ap_ready  in  1  core accepted its inputs
ap_done  in  1  core finished, single-cycle pulse
ap_idle  in  1  core idle; status only, not used by the FSM
ap_start  out  1  HLS start request
busy  out  1  high in START, WAIT_DONE, or GAP
run_count  out  CNT_W  number of completed runs; wraps modulo 2^CNT_W
run_done  out  1  one-cycle pulse per completed run
all_done  out  1  sticky; set when NUM_RUNS runs have completed
timeout_err  out  1  sticky; set on watchdog expiry

Behaviour:
Reset (rst=0) takes effect immediately, independent of clk:
- state=IDLE; all outputs 0; all counters 0.
- Reset mid-run abandons the run with no completion credited.

All outputs are registered. Decisions use inputs sampled at the clk edge.

FSM states: IDLE, START, WAIT_DONE, GAP, FINISH, ERROR.

- IDLE:
  - startCore=1 -> START.
  - ap_start goes high on the first edge that samples startCore=1 (latency 1 cycle).
- START: ap_start=1. Held until ap_ready is sampled 1.
  - ap_ready=1 and ap_done=1 in the same cycle -> run completes (see completion).
  - ap_ready=1 only -> WAIT_DONE.
  - ap_done=1 without ap_ready -> latch done_seen; stay in START.
  - A later ap_ready with done_seen set completes the run.
- WAIT_DONE: ap_start=0.
  - ap_done=1 -> run completes.
- Completion:
  - run_count += 1 and run_done pulses, both on the completing edge.
  - If NUM_RUNS != 0 and the new count == NUM_RUNS -> FINISH, all_done=1.
  - Else if GAP_CYCLES = 0 -> START; ap_start is high the cycle after the completing cycle.
  - Else -> GAP.
- GAP:
  - Counts GAP_CYCLES cycles, then enters START.
  - Exactly GAP_CYCLES cycles with ap_start=0 separate the completing cycle from the next ap_start=1.
- Watchdog (TIMEOUT_CYCLES != 0):
  - Counter clears on entry to START.
  - Increments every cycle in START or WAIT_DONE.
  - If TIMEOUT_CYCLES cycles elapse without completion -> ERROR.
  - A completion on the expiry cycle wins.
- ERROR:
  - timeout_err=1, ap_start=0, busy=0.
  - Terminal until reset.
- FINISH:
  - ap_start=0, busy=0, all_done=1.
  - Terminal; startCore is ignored.
- Common to all states:
  - startCore is a level and is consulted only in IDLE. Its dropping after IDLE is ignored.
  - run_count wraps from 2^CNT_W-1 to 0; all_done compares against the wrapped count.
  - ap_idle is never used in any decision.

Decomposition:
Shared package hls_seq_pkg holds:
- the FSM state encoding;
- localparams for the state width and the done_seen flag width.

The watchdog/gap down-counter is a natural sub-module, hls_cycle_timer:
- inputs: load, load value, enable;
- output: expired.
It is instantiated twice, once for the watchdog and once for the gap counter.

Test Plan:
1. Hold rst=0 with startCore=0 -> all outputs 0. Release rst, keep startCore=0 for 20 cycles -> ap_start stays 0, busy=0.
2. NUM_RUNS=3, GAP_CYCLES=2; core model asserts ap_ready 2 cycles after ap_start and ap_done 5 cycles after -> three ap_start bursts, each 3 cycles long; 2 idle cycles between them; run_count 1,2,3; all_done=1 after the third done; ap_start stays 0 for 50 further cycles.
3. NUM_RUNS=1; ap_ready and ap_done both high on the first ap_start cycle -> ap_start high exactly 1 cycle, run_done pulses once, all_done=1 on that edge.
4. TIMEOUT_CYCLES=16; core asserts ap_ready but never ap_done -> timeout_err=1 exactly 16 cycles after ap_start first rose. timeout_err stays 1 and ap_start stays 0 thereafter, even though startCore stays high.
5. Assert rst=0 mid-WAIT_DONE -> immediately ap_start=0 and run_count=0. After release with startCore=1, ap_start rises 1 cycle later.
6. NUM_RUNS=0, GAP_CYCLES=0, CNT_W=4; single-cycle ready+done core -> run_count counts 15 then 0 and continues; all_done never sets.
